preempt_ctrl: RTL

PREEMPT_CTRL -- requirements
Module: preempt_ctrl

---
 rtl/preempt_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/preempt_ctrl.sv
// Preemption controller: latches interrupt edges and quantum expiry, then issues one
// registered context-switch request at a time and tracks it through accept and service.
module preempt_ctrl #(
  parameter int NSRC = 4,
  parameter int QW   = 32,
  parameter int IDW  = 3
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            quantum_load,
  input  logic [QW-1:0]   quantum_value,
  input  logic [NSRC-1:0] irq_in,
  input  logic [NSRC-1:0] irq_mask,
  input  logic            halt,
  input  logic            ack,
  input  logic            done,
  output logic            req,
  output logic [IDW-1:0]  req_id,
  output logic [NSRC-1:0] pending,
  output logic [QW-1:0]   time_left,
  output logic            busy
);

  typedef enum logic [1:0] {RUN, REQ, SVC} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  reqId_q, reqId_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] irqPrev_q;
  logic [QW-1:0]   timeLeft_q, timeLeft_d;
  logic            running_q, running_d;
  logic            qexp_q, qexp_d;

  logic [NSRC-1:0] irqEdge;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] pendingClr;
  logic [IDW-1:0]  winner;
  logic            candFound;
  logic            qexpClr;
  logic            qexpSet;

  assign irqEdge = irq_in & ~irqPrev_q;
  assign cand    = pending_q & ~irq_mask;

  // Lowest unmasked source wins; quantum expiry only when no external source competes.
  always_comb begin
    winner    = IDW'(NSRC);
    candFound = qexp_q;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner    = IDW'(i);
        candFound = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    reqId_d    = reqId_q;
    pendingClr = '0;
    qexpClr    = 1'b0;
    case (state_q)
      RUN: begin
        if (!halt && candFound) begin
          state_d = REQ;
          reqId_d = winner;
        end
      end
      REQ: begin
        if (ack) begin
          state_d = SVC;
          if (reqId_q == IDW'(NSRC)) begin
            qexpClr = 1'b1;
          end else begin
            pendingClr = NSRC'(1) << reqId_q;
          end
        end
      end
      SVC: begin
        if (done) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // A load always beats the decrement, so an expiry step coinciding with a load never fires.
  always_comb begin
    timeLeft_d = timeLeft_q;
    running_d  = running_q;
    qexpSet    = 1'b0;
    if (quantum_load) begin
      timeLeft_d = quantum_value;
      running_d  = |quantum_value;
    end else if (running_q && !halt && state_q != SVC && timeLeft_q != '0) begin
      timeLeft_d = timeLeft_q - QW'(1);
      if (timeLeft_q == QW'(1)) begin
        running_d = 1'b0;
        qexpSet   = 1'b1;
      end
    end
  end

  // New events win over a same-cycle clear so nothing arriving during ack is lost.
  assign pending_d = (pending_q & ~pendingClr) | irqEdge;
  assign qexp_d    = (qexp_q & ~qexpClr) | qexpSet;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      reqId_q    <= '0;
      pending_q  <= '0;
      irqPrev_q  <= '0;
      timeLeft_q <= '0;
      running_q  <= 1'b0;
      qexp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reqId_q    <= reqId_d;
      pending_q  <= pending_d;
      irqPrev_q  <= irq_in;
      timeLeft_q <= timeLeft_d;
      running_q  <= running_d;
      qexp_q     <= qexp_d;
    end
  end

  assign req       = (state_q == REQ);
  assign busy      = (state_q == SVC);
  assign req_id    = reqId_q;
  assign pending   = pending_q;
  assign time_left = timeLeft_q;

endmodule
